// File: rtl/imem_loader_if.sv
// Write-side bus bundle for imem_loader: the incoming byte stream plus the memory write port.
interface imem_loader_if #(
    parameter int ADDR_W = 9
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_d;
    logic              mem_we;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, mem_a, mem_d, mem_we
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, mem_a, mem_d, mem_we
    );
endinterface

// File: rtl/imem_loader.sv
// Packs a byte stream into 32-bit words and writes them to consecutive instruction memory
// locations, holding the CPU in reset meanwhile. Optional running checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W     = 9,
    parameter int BASE_ADDR  = 0,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    imem_loader_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ONE  = (ADDR_W+1)'(1);

    state_t            state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   word_cnt;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_buf;
    logic [31:0]       next_word;

    always_comb begin
        next_word = BIG_ENDIAN ? {word_buf[23:0], bus.byte_in}
                               : {bus.byte_in, word_buf[31:8]};
    end

    // All outputs are registered; they change together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            bus.byte_ready <= 1'b0;
            bus.mem_a      <= BASE;
            bus.mem_d      <= '0;
            bus.mem_we     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cpu_hold       <= 1'b0;
            len_q          <= '0;
            word_cnt       <= '0;
            byte_cnt       <= '0;
            word_buf       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        cpu_hold  <= 1'b1;
                        word_cnt  <= '0;
                        byte_cnt  <= '0;
                        bus.mem_a <= BASE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum  <= '0;
`endif
                        if (len != '0) begin
                            len_q          <= len;
                            bus.byte_ready <= 1'b1;
                            state          <= S_RECV;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_RECV: begin
                    if (bus.byte_valid && bus.byte_ready) begin
                        word_buf <= next_word;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bus.byte_ready <= 1'b0;
                            bus.mem_d      <= next_word;
                            bus.mem_we     <= 1'b1;
                            state          <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    bus.mem_we <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum   <= checksum + bus.mem_d;
`endif
                    // mem_a wraps naturally at the top of the address space
                    if (word_cnt == len_q - ONE) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        word_cnt       <= word_cnt + ONE;
                        bus.mem_a      <= bus.mem_a + 1'b1;
                        bus.byte_ready <= 1'b1;
                        state          <= S_RECV;
                    end
                end
                S_DONE: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: three instances (default, little-endian, base 510).
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start0, start1, start2;
    logic [9:0] len0, len1, len2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       hold0, hold1, hold2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] cs0, cs1, cs2;
`endif

    imem_loader_if #(.ADDR_W(9)) bus0 ();
    imem_loader_if #(.ADDR_W(9)) bus1 ();
    imem_loader_if #(.ADDR_W(9)) bus2 ();

    imem_loader #(.ADDR_W(9), .BASE_ADDR(0), .BIG_ENDIAN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .len(len0), .bus(bus0),
        .busy(busy0), .done(done0), .cpu_hold(hold0)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(cs0)
`endif
    );
    imem_loader #(.ADDR_W(9), .BASE_ADDR(0), .BIG_ENDIAN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .len(len1), .bus(bus1),
        .busy(busy1), .done(done1), .cpu_hold(hold1)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(cs1)
`endif
    );
    imem_loader #(.ADDR_W(9), .BASE_ADDR(510), .BIG_ENDIAN(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .len(len2), .bus(bus2),
        .busy(busy2), .done(done2), .cpu_hold(hold2)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(cs2)
`endif
    );

    typedef struct {
        logic [8:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp0[$], exp1[$], exp2[$];
    logic [7:0] txq[$];
    int         tests_run = 0;
    int         tests_failed = 0;
    int         cyc = 0;
    int         we0 = 0, we1 = 0, we2 = 0;
    int         start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic pushExp(input int which, input logic [8:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        case (which)
            0: exp0.push_back(e);
            1: exp1.push_back(e);
            default: exp2.push_back(e);
        endcase
    endtask

    task automatic scoreWrite(input int which, input logic [8:0] a, input logic [31:0] d);
        wr_t e;
        bit  have;
        have = 1'b0;
        e.a = '0;
        e.d = '0;
        case (which)
            0: if (exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
            1: if (exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
            default: if (exp2.size() > 0) begin e = exp2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL dut%0d unexpected write: got a=%0d d=0x%08h, expected none", which, a, d);
        end else begin
            checkOutput($sformatf("dut%0d write addr", which), 32'(a), 32'(e.a));
            checkOutput($sformatf("dut%0d write data", which), d, e.d);
        end
    endtask

    // Monitor: every write seen on a memory port is matched against the scoreboard.
    always @(negedge clk) begin
        if (bus0.mem_we) begin we0++; scoreWrite(0, bus0.mem_a, bus0.mem_d); end
        if (bus1.mem_we) begin we1++; scoreWrite(1, bus1.mem_a, bus1.mem_d); end
        if (bus2.mem_we) begin we2++; scoreWrite(2, bus2.mem_a, bus2.mem_d); end
    end

    task automatic drive(input int which, input logic v, input logic [7:0] b);
        case (which)
            0: begin bus0.byte_valid = v; bus0.byte_in = b; end
            1: begin bus1.byte_valid = v; bus1.byte_in = b; end
            default: begin bus2.byte_valid = v; bus2.byte_in = b; end
        endcase
    endtask

    function automatic logic readyOf(input int which);
        case (which)
            0: return bus0.byte_ready;
            1: return bus1.byte_ready;
            default: return bus2.byte_ready;
        endcase
    endfunction

    function automatic logic doneOf(input int which);
        case (which)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    task automatic pulseStart(input int which, input logic [9:0] l);
        case (which)
            0: begin start0 = 1'b1; len0 = l; end
            1: begin start1 = 1'b1; len1 = l; end
            default: begin start2 = 1'b1; len2 = l; end
        endcase
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        start_cyc = cyc;
    endtask

    // Starts a load and streams txq; entered and left on a negative edge.
    task automatic applyStimulus(input int which, input logic [9:0] l, input int gap_max);
        int guard;
        pulseStart(which, l);
        foreach (txq[i]) begin
            repeat ($urandom_range(0, gap_max)) begin
                drive(which, 1'b0, 8'h00);
                @(negedge clk);
            end
            drive(which, 1'b1, txq[i]);
            guard = 0;
            while (!readyOf(which) && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL dut%0d byte_ready timeout: got 0, expected 1", which);
            end
            @(posedge clk);
            @(negedge clk);
        end
        drive(which, 1'b0, 8'h00);
        txq.delete();
    endtask

    task automatic waitDone(input int which, input int budget);
        int n;
        n = 0;
        while (!doneOf(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL dut%0d done timeout: got 0, expected 1", which);
        end
    endtask

    initial begin
        int w;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        len0 = '0; len1 = '0; len2 = '0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);

        repeat (2) @(negedge clk);
        checkOutput("reset byte_ready", 32'(bus0.byte_ready), 32'd0);
        checkOutput("reset mem_a", 32'(bus0.mem_a), 32'd0);
        checkOutput("reset mem_a base510", 32'(bus2.mem_a), 32'd510);
        checkOutput("reset mem_d", bus0.mem_d, 32'd0);
        checkOutput("reset mem_we", 32'(bus0.mem_we), 32'd0);
        checkOutput("reset busy/done/hold", {29'd0, busy0, done0, hold0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two big-endian words, valid held high, done exactly 10 cycles after start
        pushExp(0, 9'd0, 32'h12345678);
        pushExp(0, 9'd1, 32'hAABBCCDD);
        txq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        applyStimulus(0, 10'd2, 0);
        waitDone(0, 20);
        checkOutput("t1 done latency", 32'(cyc - start_cyc), 32'd10);
`ifdef IMEM_LOADER_CHECKSUM_EN
        checkOutput("t7 checksum", cs0, 32'hBCF02355);
`endif
        @(negedge clk);
        checkOutput("t1 done width", 32'(done0), 32'd0);
        checkOutput("t1 cpu_hold after", 32'(hold0), 32'd0);
        checkOutput("t1 mem_d holds last", bus0.mem_d, 32'hAABBCCDD);

        // Little-endian packing
        pushExp(1, 9'd0, 32'h78563412);
        txq = '{8'h12, 8'h34, 8'h56, 8'h78};
        applyStimulus(1, 10'd1, 0);
        waitDone(1, 20);
        @(negedge clk);

        // Random gaps in the stream must not lose or duplicate bytes
        w = we0;
        pushExp(0, 9'd0, 32'hDEADBEEF);
        pushExp(0, 9'd1, 32'h01234567);
        pushExp(0, 9'd2, 32'h89ABCDEF);
        txq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67,
                8'h89, 8'hAB, 8'hCD, 8'hEF};
        applyStimulus(0, 10'd3, 3);
        waitDone(0, 40);
        checkOutput("t3 write count", 32'(we0 - w), 32'd3);
        @(negedge clk);

        // Zero-length load
        w = we0;
        pulseStart(0, 10'd0);
        checkOutput("t4 busy", 32'(busy0), 32'd1);
        checkOutput("t4 done", 32'(done0), 32'd1);
        @(negedge clk);
        checkOutput("t4 idle", {30'd0, busy0, done0}, 32'd0);
        checkOutput("t4 no writes", 32'(we0 - w), 32'd0);

        // Address wrap from BASE_ADDR=510
        pushExp(2, 9'd510, 32'h01020304);
        pushExp(2, 9'd511, 32'h05060708);
        pushExp(2, 9'd0,   32'h090A0B0C);
        pushExp(2, 9'd1,   32'h0D0E0F10);
        txq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
        applyStimulus(2, 10'd4, 0);
        waitDone(2, 20);
        @(negedge clk);

        // Reset in the middle of the second word
        pushExp(0, 9'd0, 32'hCAFEF00D);
        txq = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h11, 8'h22};
        applyStimulus(0, 10'd2, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("t6 rst byte_ready", 32'(bus0.byte_ready), 32'd0);
        checkOutput("t6 rst mem_a", 32'(bus0.mem_a), 32'd0);
        checkOutput("t6 rst mem_d", bus0.mem_d, 32'd0);
        checkOutput("t6 rst busy/done/hold/we", {28'd0, busy0, done0, hold0, bus0.mem_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pushExp(0, 9'd0, 32'h33445566);
        txq = '{8'h33, 8'h44, 8'h55, 8'h66};
        applyStimulus(0, 10'd1, 0);
        waitDone(0, 20);
        @(negedge clk);
        @(negedge clk);

        checkOutput("dut0 pending writes", 32'(exp0.size()), 32'd0);
        checkOutput("dut1 pending writes", 32'(exp1.size()), 32'd0);
        checkOutput("dut2 pending writes", 32'(exp2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
